// File: rtl/vlogic_unit_if.sv
// Handshake and operand bundle for vlogic_unit.
// master drives operations and out_ready; slave is the unit.
interface vlogic_unit_if #(
    parameter int DATA_WIDTH = 64
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int VLW = $clog2(NB) + 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            op;
    logic [1:0]            sew;
    logic [VLW-1:0]        vl;
    logic                  mask_en;
    logic [NB-1:0]         mask;
    logic [DATA_WIDTH-1:0] operand_1;
    logic [DATA_WIDTH-1:0] operand_2;
    logic [DATA_WIDTH-1:0] old_dest;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;
    logic                  busy;

    modport master (
        output in_valid, op, sew, vl, mask_en, mask,
               operand_1, operand_2, old_dest, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, sew, vl, mask_en, mask,
               operand_1, operand_2, old_dest, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/vlogic_unit.sv
// Masked, vl-limited bitwise logic unit with a globally stalled pipeline.
// The merge is done before stage 0, so later stages only carry finished data.
module vlogic_unit #(
    parameter int DATA_WIDTH = 64,
    parameter int PIPE_DEPTH = 2
) (
    input logic         clk,
    input logic         rst_n,
    vlogic_unit_if.slave io
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = $clog2(NB);

    logic                  adv;
    logic [DATA_WIDTH-1:0] op_res;
    logic [DATA_WIDTH-1:0] merged;
    logic [IW-1:0]         eidx;
    logic                  act;

    logic [PIPE_DEPTH-1:0] valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q [PIPE_DEPTH];
    logic [DATA_WIDTH-1:0] data_d [PIPE_DEPTH];

    assign adv          = !(valid_q[PIPE_DEPTH-1] && !io.out_ready);
    assign io.in_ready  = adv;
    assign io.out_valid = valid_q[PIPE_DEPTH-1];
    assign io.result    = data_q[PIPE_DEPTH-1];
    assign io.busy      = |valid_q;

    always_comb begin
        op_res = '0;
        case (io.op)
            3'b000:  op_res = io.operand_1 & io.operand_2;
            3'b001:  op_res = io.operand_1 | io.operand_2;
            3'b010:  op_res = io.operand_1 ^ io.operand_2;
            3'b011:  op_res = io.operand_1 & ~io.operand_2;
            3'b100:  op_res = ~(io.operand_1 & io.operand_2);
            3'b101:  op_res = ~(io.operand_1 | io.operand_2);
            3'b110:  op_res = ~(io.operand_1 ^ io.operand_2);
            default: op_res = io.operand_1 | ~io.operand_2;
        endcase
    end

    // Work per byte: a byte belongs to element (byte >> sew), which never
    // reaches E, so mask bits beyond the element count are never looked at.
    always_comb begin
        merged = '0;
        eidx   = '0;
        act    = 1'b0;
        for (int b = 0; b < NB; b++) begin
            eidx = IW'(b >> io.sew);
            act  = ({1'b0, eidx} < io.vl) && (!io.mask_en || io.mask[eidx]);
            merged[b*8 +: 8] = act ? op_res[b*8 +: 8] : io.old_dest[b*8 +: 8];
        end
    end

    always_comb begin
        valid_d = valid_q;
        for (int s = 0; s < PIPE_DEPTH; s++) data_d[s] = data_q[s];
        if (adv) begin
            valid_d[0] = io.in_valid;
            data_d[0]  = merged;
            for (int s = 1; s < PIPE_DEPTH; s++) begin
                valid_d[s] = valid_q[s-1];
                data_d[s]  = data_q[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int s = 0; s < PIPE_DEPTH; s++) data_q[s] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int s = 0; s < PIPE_DEPTH; s++) data_q[s] <= data_d[s];
        end
    end
endmodule

// File: tb/tb_vlogic_unit.sv
// Self-checking bench for vlogic_unit: directed scenarios plus a randomized
// op/sew sweep scored against an element-level reference merge.
module tb_vlogic_unit;
    localparam int DW  = 64;
    localparam int PD  = 2;
    localparam int NB  = DW / 8;
    localparam int VLW = $clog2(NB) + 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   n_xfer;
    logic [DW-1:0] sbq [$];

    vlogic_unit_if #(.DATA_WIDTH(DW)) io ();

    vlogic_unit #(.DATA_WIDTH(DW), .PIPE_DEPTH(PD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic bit_op(input logic [2:0] op, input logic a, input logic b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return a & ~b;
            3'd4: return ~(a & b);
            3'd5: return ~(a | b);
            3'd6: return ~(a ^ b);
            default: return a | ~b;
        endcase
    endfunction

    function automatic logic [DW-1:0] ref_merge(
        input logic [2:0] op, input logic [1:0] sew, input logic [VLW-1:0] vl,
        input logic men, input logic [NB-1:0] m,
        input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] old);
        int esz;
        int ne;
        logic [DW-1:0] r;
        esz = 8 << sew;
        ne  = DW / esz;
        r   = old;
        for (int i = 0; i < ne; i++) begin
            if (i < int'(vl) && (!men || m[i])) begin
                for (int j = 0; j < esz; j++)
                    r[i*esz + j] = bit_op(op, a[i*esz + j], b[i*esz + j]);
            end
        end
        return r;
    endfunction

    // Scoreboard: push at acceptance, pop at output transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
        end else begin
            if (io.out_valid && io.out_ready) begin
                n_xfer++;
                if (sbq.size() == 0) chk("spurious_out", 1, 0);
                else chk("sb_result", io.result, sbq.pop_front());
            end
            if (io.in_valid && io.in_ready)
                sbq.push_back(ref_merge(io.op, io.sew, io.vl, io.mask_en, io.mask,
                                        io.operand_1, io.operand_2, io.old_dest));
        end
    end

    task automatic send(input logic [2:0] op, input logic [1:0] sew, input logic [VLW-1:0] vl,
                        input logic men, input logic [NB-1:0] m, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] old, input bit rand_rdy);
        logic acc;
        io.op = op; io.sew = sew; io.vl = vl; io.mask_en = men; io.mask = m;
        io.operand_1 = a; io.operand_2 = b; io.old_dest = old;
        io.in_valid = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 64 && !acc; c++) begin
            @(negedge clk);
            acc = io.in_ready;
            @(posedge clk);
            #1;
            if (rand_rdy) io.out_ready = 1'($urandom_range(0, 1));
        end
        if (!acc) chk("send_timeout", 0, 1);
        io.in_valid = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [2:0] op, input logic [1:0] sew,
                           input logic [VLW-1:0] vl, input logic men, input logic [NB-1:0] m,
                           input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] old, input logic [DW-1:0] exp);
        io.out_ready = 1'b1;
        send(op, sew, vl, men, m, a, b, old, 0);
        chk({tag, "_busy"}, io.busy, 1);
        repeat (PD - 1) begin
            chk({tag, "_early"}, io.out_valid, 0);
            @(posedge clk); #1;
        end
        chk({tag, "_valid"}, io.out_valid, 1);
        chk({tag, "_result"}, io.result, exp);
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag);
        int c;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        c = 0;
        while (io.busy && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
        chk({tag, "_busy"}, io.busy, 0);
        chk({tag, "_sb_empty"}, sbq.size(), 0);
    endtask

    initial begin
        int x0;
        logic [DW-1:0] a, b, ea;
        checks = 0; errors = 0; n_xfer = 0;
        io.in_valid = 0; io.op = 0; io.sew = 0; io.vl = 0; io.mask_en = 0; io.mask = 0;
        io.operand_1 = 0; io.operand_2 = 0; io.old_dest = 0; io.out_ready = 1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", io.out_valid, 0);
        chk("rst_busy", io.busy, 0);
        chk("rst_result", io.result, 0);
        chk("rst_in_ready", io.in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_rst_in_ready", io.in_ready, 1);

        run_one("and64", 3'b000, 2'b11, 1, 0, 0, 64'hFFFF_0000_FFFF_0000,
                64'h0F0F_0F0F_0F0F_0F0F, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0000_0F0F_0000);
        run_one("xor8_mask", 3'b010, 2'b00, 8, 1, 8'h55, {DW{1'b1}}, 0, 0,
                64'h00FF_00FF_00FF_00FF);
        run_one("nor16_tail", 3'b101, 2'b01, 2, 0, 0, 0, 0, 64'hAAAA_AAAA_AAAA_AAAA,
                64'hAAAA_AAAA_FFFF_FFFF);
        run_one("vl0", 3'b001, 2'b00, 0, 0, 0, {DW{1'b1}}, {DW{1'b1}},
                64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
        run_one("vl_big", 3'b100, 2'b10, 4'd9, 0, 0, 64'hF0F0_F0F0_0000_FFFF,
                64'hFFFF_FFFF_FFFF_0000, 64'h5555_5555_5555_5555, 64'h0F0F_0F0F_FFFF_FFFF);
        run_one("mask_hi_ignored", 3'b111, 2'b11, 1, 1, 8'hFE, 0, {DW{1'b1}},
                64'hDEAD_BEEF_DEAD_BEEF, 64'hDEAD_BEEF_DEAD_BEEF);
        drain("directed");

        // Stall: three back-to-back ops with the output blocked.
        x0 = n_xfer;
        a  = {$urandom, $urandom};
        b  = {$urandom, $urandom};
        ea = ref_merge(3'b010, 2'b10, 2, 0, 0, a, b, 0);
        io.out_ready = 1'b0;
        send(3'b010, 2'b10, 2, 0, 0, a, b, 0, 0);
        send(3'b000, 2'b01, 3, 1, 8'h0F, {$urandom, $urandom}, {$urandom, $urandom}, 64'h1, 0);
        io.op = 3'b110; io.sew = 2'b00; io.vl = 5; io.mask_en = 0;
        io.operand_1 = {$urandom, $urandom}; io.operand_2 = {$urandom, $urandom};
        io.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", io.in_ready, 0);
            chk("stall_out_valid", io.out_valid, 1);
            chk("stall_result_hold", io.result, ea);
            @(posedge clk); #1;
            io.operand_1 = {$urandom, $urandom};
        end
        io.out_ready = 1'b1;
        send(io.op, io.sew, io.vl, io.mask_en, io.mask, io.operand_1, io.operand_2,
             io.old_dest, 0);
        drain("stall");
        chk("stall_xfer_count", n_xfer - x0, 3);

        // Reset with two operations in flight.
        io.out_ready = 1'b1;
        send(3'b001, 2'b00, 8, 0, 0, {$urandom, $urandom}, {$urandom, $urandom}, 0, 0);
        send(3'b011, 2'b11, 1, 0, 0, {$urandom, $urandom}, {$urandom, $urandom}, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", io.out_valid, 0);
        chk("midrst_busy", io.busy, 0);
        chk("midrst_result", io.result, 0);
        chk("midrst_in_ready", io.in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        x0 = n_xfer;
        repeat (5) begin
            @(negedge clk);
            chk("postrst_no_stale", io.out_valid, 0);
            @(posedge clk); #1;
        end
        chk("postrst_xfer", n_xfer - x0, 0);

        // Sweep every op and sew with random vl/mask/operands and output stalls.
        x0 = n_xfer;
        for (int op = 0; op < 8; op++) begin
            for (int sw = 0; sw < 4; sw++) begin
                for (int r = 0; r < 4; r++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                        io.out_ready = 1'($urandom_range(0, 1));
                    end
                    send(3'(op), 2'(sw), VLW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                         NB'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                         {$urandom, $urandom}, 1);
                end
            end
        end
        drain("sweep");
        chk("sweep_xfer_count", n_xfer - x0, 128);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        chk("global_timeout", 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vlogic_unit.md
VLOGIC_UNIT -- requirements
Module: vlogic_unit

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 64, giving the lane datapath width in bits; legal values are multiples of 64.
REQ-002 The module SHALL have parameter PIPE_DEPTH, default 2, giving the number of register stages; legal range is 1..4.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The module SHALL have port in_valid, input, 1 bit: the upstream operation is valid.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the unit accepts the operation this cycle.
REQ-007 The module SHALL have port op, input, 3 bits: 000 AND, 001 OR, 010 XOR, 011 ANDN (a&~b), 100 NAND, 101 NOR, 110 XNOR, 111 ORN (a|~b).
REQ-008 The module SHALL have port sew, input, 2 bits: element width, where 00=8, 01=16, 10=32, 11=64 bits.
REQ-009 The module SHALL have port vl, input, $clog2(DATA_WIDTH/8)+1 bits: the active element count.
REQ-010 The module SHALL have ports mask_en (1 bit) and mask (DATA_WIDTH/8 bits), both inputs: mask[i] governs element i.
REQ-011 The module SHALL have ports operand_1, operand_2 and old_dest, each input, DATA_WIDTH bits: the sources and the prior destination value.
REQ-012 The module SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): the downstream handshake.
REQ-013 The module SHALL have port result, output, DATA_WIDTH bits: the merged result.
REQ-014 The module SHALL have port busy, output, 1 bit: high when any pipeline stage holds a valid operation.

Function
REQ-015 An operation SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-016 The pipeline SHALL advance when adv = !(out_valid && !out_ready); in_ready SHALL equal adv (global stall, no bubble collapse).
REQ-017 When adv=0, every stage, including result and out_valid, SHALL hold its value.
REQ-018 An operation accepted at edge N SHALL appear with out_valid=1 after edge N+PIPE_DEPTH-1, provided no stall occurs; each stall cycle adds one cycle.
REQ-019 The transfer at the output SHALL complete on an edge where out_valid && out_ready.
REQ-020 Throughput SHALL be one operation per cycle with out_ready held at 1.
REQ-021 Element count SHALL be E = DATA_WIDTH/SEW, and element i SHALL occupy bits [i*SEW +: SEW].
REQ-022 Element i SHALL be active iff i < vl and (mask_en==0 or mask[i]==1).
REQ-023 For SEW>8, mask bits with index >= E SHALL be ignored.
REQ-024 An active element SHALL take op(operand_1, operand_2) bitwise.
REQ-025 An inactive element, whether tail or masked, SHALL take old_dest bits unchanged.
REQ-026 When vl >= E, all elements SHALL be eligible; when vl = 0, result SHALL equal old_dest.
REQ-027 op, sew, vl, mask and operands SHALL be sampled only at acceptance and carried with the operation; later input changes SHALL NOT affect in-flight results.
REQ-028 in_valid=0 at an advancing edge SHALL insert a bubble; out_valid SHALL be 0 for that slot.
REQ-029 busy SHALL be the OR of all stage valid bits.

Reset
REQ-030 While rst_n=0, all stage valid bits, out_valid and busy SHALL be 0, and result SHALL be 0, asynchronously.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operations; no result from before reset SHALL appear afterwards.
REQ-032 in_ready SHALL be 1 during and immediately after reset, since out_valid is 0.

Verification
REQ-033 Scenario: PIPE_DEPTH=2, sew=11, vl=1, mask_en=0, op=000, op1=FFFF_0000_FFFF_0000, op2=0F0F_0F0F_0F0F_0F0F -> after 2 edges, result=0F0F_0000_0F0F_0000 with out_valid=1.
REQ-034 Scenario: sew=00, vl=8, mask_en=1, mask=0x55, op=010, op1=all FF, op2=0, old_dest=0 -> result=00FF_00FF_00FF_00FF.
REQ-035 Scenario: sew=01, vl=2, mask_en=0, op=101, op1=op2=0, old_dest=AAAA_AAAA_AAAA_AAAA -> result=AAAA_AAAA_FFFF_FFFF.
REQ-036 Scenario: issue 3 back-to-back ops with out_ready=0 for 3 cycles -> in_ready=0 while out_valid=1; result holds the first op; on release, results arrive in order with no loss or duplication.
REQ-037 Scenario: rst_n pulled low with 2 ops in flight -> out_valid=0, busy=0 and result=0 immediately; no stale output appears after release.
REQ-038 Scenario: sweep all 8 op codes × 4 sew values with random vl/mask -> result matches the reference merge model on every transfer.
